// File: rtl/mul_div_seq.sv
// mul_div_seq -- sequential signed multiplier / divider.
//
// Multiplication uses radix-2 Booth, one iteration per clock for 32 iterations.
// Division uses non-restoring division on the operand magnitudes, one iteration
// per clock for 32 iterations. A final FIX cycle then corrects the remainder
// and applies the signs.
//
// Division support is compiled in only when the macro MULDIV_DIV_EN is
// defined. Without it, the Div opcode is ignored and div_by_zero is tied to 0.
//
// Ports:
//   clock        rising-edge clock
//   clear        asynchronous active-low reset
//   start        operation request, sampled only in IDLE
//   opcode[4:0]  operation select: Mul = 5'b01111, Div = 5'b10000, others ignored
//   A, B         signed operands (multiplicand/multiplier or dividend/divisor)
//   busy         high while an operation is in progress
//   done         one-cycle pulse when C_out_HI/C_out_LO carry a new result
//   div_by_zero  high when the last Div had B == 0 (valid from done to the next start)
//   C_out_HI     product[63:32], or the remainder
//   C_out_LO     product[31:0], or the quotient
module mul_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] C_out_HI,
    output logic [WIDTH-1:0] C_out_LO
);
    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [4:0]    OP_MUL    = 5'b01111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t        state;
    logic [CW-1:0] count;

    // The Booth accumulator carries two guard bits so that subtracting the
    // most negative multiplicand cannot overflow.
    logic [WIDTH+1:0] mcand;
    logic [WIDTH+1:0] m_hi;
    logic [WIDTH-1:0] m_lo;
    logic             m_q1;
    logic [WIDTH+1:0] m_sum;
    logic [WIDTH+1:0] m_hi_next;
    logic [WIDTH-1:0] m_lo_next;

    always_comb begin
        case ({m_lo[0], m_q1})
            2'b01:   m_sum = m_hi + mcand;
            2'b10:   m_sum = m_hi - mcand;
            default: m_sum = m_hi;
        endcase
        // Arithmetic shift right of the combined {hi, lo, q-1} register.
        m_hi_next = {m_sum[WIDTH+1], m_sum[WIDTH+1:1]};
        m_lo_next = {m_sum[0], m_lo[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    localparam logic [4:0] OP_DIV = 5'b10000;

    logic [WIDTH-1:0] d_mag;     // divisor magnitude
    logic [WIDTH-1:0] q;         // dividend bits shift out, quotient bits shift in
    logic [WIDTH+1:0] r;         // signed partial remainder
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH+1:0] r_shift;
    logic [WIDTH+1:0] r_next;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        a_mag   = A[WIDTH-1] ? (~A + 1'b1) : A;
        b_mag   = B[WIDTH-1] ? (~B + 1'b1) : B;
        r_shift = {r[WIDTH:0], q[WIDTH-1]};
        r_next  = r[WIDTH+1] ? (r_shift + {2'b00, d_mag}) : (r_shift - {2'b00, d_mag});
        // The corrected remainder lies in [0, d), so WIDTH bits hold it exactly.
        r_fix   = r[WIDTH-1:0] + (r[WIDTH+1] ? d_mag : '0);
    end
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            C_out_HI <= '0;
            C_out_LO <= '0;
            mcand    <= '0;
            m_hi     <= '0;
            m_lo     <= '0;
            m_q1     <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_by_zero <= 1'b0;
            d_mag       <= '0;
            q           <= '0;
            r           <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && opcode == OP_MUL) begin
                        mcand <= {{2{A[WIDTH-1]}}, A};
                        m_hi  <= '0;
                        m_lo  <= B;
                        m_q1  <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= MUL;
`ifdef MULDIV_DIV_EN
                        div_by_zero <= 1'b0;
                    end else if (start && opcode == OP_DIV) begin
                        d_mag    <= b_mag;
                        // With a zero divisor no iterations run, so q is free
                        // to carry the raw dividend through to C_out_HI.
                        q        <= (B == '0) ? A : a_mag;
                        r        <= '0;
                        neg_q    <= A[WIDTH-1] ^ B[WIDTH-1];
                        neg_r    <= A[WIDTH-1];
                        zero_div <= (B == '0);
                        count    <= '0;
                        busy     <= 1'b1;
                        div_by_zero <= 1'b0;
                        state    <= (B == '0) ? FIX : DIV;
`endif
                    end
                end
                MUL: begin
                    m_hi  <= m_hi_next;
                    m_lo  <= m_lo_next;
                    m_q1  <= m_lo[0];
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        C_out_HI <= m_hi_next[WIDTH-1:0];
                        C_out_LO <= m_lo_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
`ifdef MULDIV_DIV_EN
                DIV: begin
                    r     <= r_next;
                    q     <= {q[WIDTH-2:0], ~r_next[WIDTH+1]};
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zero_div) begin
                        C_out_HI    <= q;
                        C_out_LO    <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        C_out_HI <= neg_r ? (~r_fix + 1'b1) : r_fix;
                        C_out_LO <= neg_q ? (~q + 1'b1) : q;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed testbench for mul_div_seq: a table of operations with hand-computed
// results and latencies, plus short sequences for ignored starts, a start
// during busy, and reset in the middle of an operation.
// Division expectations apply when MULDIV_DIV_EN is defined. Otherwise the
// Div vectors are expected to be ignored.
module tb_mul_div_seq;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_ADD = 5'b00000;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock;
    logic        clear;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] C_out_HI;
    logic [31:0] C_out_LO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs [0:15];

    mul_div_seq #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .opcode      (opcode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .C_out_HI    (C_out_HI),
        .C_out_LO    (C_out_LO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Applies one operation. start is raised immediately, so back-to-back
    // calls also exercise acceptance in the done cycle. Inputs are scrambled
    // right after the start edge.
    task automatic run_op(input vec_t v);
        int   lat;
        int   overlap;
        logic busy_e1;
        lat     = -1;
        overlap = 0;
        busy_e1 = 1'b0;
        start   = 1'b1;
        opcode  = v.op;
        A       = v.a;
        B       = v.b;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clock);
            #1;
            if (busy && done) overlap++;
            if (e == 1) begin
                busy_e1 = busy;
                start   = 1'b0;
                opcode  = OP_DIV;
                A       = ~v.a;
                B       = v.b ^ 32'h5A5A_0F0F;
            end
            if (done) begin
                lat = e;
                break;
            end
        end
        $display("%-14s op=%b A=%h B=%h -> edges=%0d HI=%h LO=%h dbz=%b",
                 v.name, v.op, v.a, v.b, lat, C_out_HI, C_out_LO, div_by_zero);
        check({v.name, ".busy_at_start"}, 64'(busy_e1), 64'(1));
        check({v.name, ".latency"}, 64'(lat), 64'(v.lat));
        check({v.name, ".hi"}, 64'(C_out_HI), 64'(v.hi));
        check({v.name, ".lo"}, 64'(C_out_LO), 64'(v.lo));
        check({v.name, ".dbz"}, 64'(div_by_zero), 64'(v.dbz));
        check({v.name, ".busy_done_overlap"}, 64'(overlap), 64'(0));
    endtask

    // Holds start with an opcode that must be ignored and expects no activity.
    task automatic check_ignored(input string name, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        int seen_busy;
        int seen_done;
        seen_busy = 0;
        seen_done = 0;
        start  = 1'b1;
        opcode = op;
        A      = a;
        B      = b;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (busy) seen_busy++;
            if (done) seen_done++;
        end
        start = 1'b0;
        $display("%-14s op=%b A=%h B=%h -> busy cycles=%0d done pulses=%0d",
                 name, op, a, b, seen_busy, seen_done);
        check({name, ".busy"}, 64'(seen_busy), 64'(0));
        check({name, ".done"}, 64'(seen_done), 64'(0));
    endtask

    initial begin
        int lat;
        int done_cnt;

        vecs[0]  = '{"mul_6x7",      OP_MUL, 32'd6,        32'd7,        33, 32'h0000_0000, 32'd42,        1'b0};
        vecs[1]  = '{"mul_m3x5",     OP_MUL, 32'hFFFF_FFFD, 32'd5,        33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2]  = '{"mul_min_min",  OP_MUL, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{"mul_max_max",  OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[4]  = '{"mul_min_max",  OP_MUL, 32'h8000_0000, 32'h7FFF_FFFF, 33, 32'hC000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{"div_m7_2",     OP_DIV, 32'hFFFF_FFF9, 32'd2,        34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[6]  = '{"div_13_0",     OP_DIV, 32'd13,       32'd0,         2, 32'd13,        32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{"mul_m1_m1",    OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[8]  = '{"div_min_m1",   OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[9]  = '{"div_100_7",    OP_DIV, 32'd100,      32'd7,        34, 32'd2,         32'd14,        1'b0};
        vecs[10] = '{"div_7_m2",     OP_DIV, 32'd7,        32'hFFFF_FFFE, 34, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[11] = '{"div_m100_m7",  OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, 32'hFFFF_FFFE, 32'd14,        1'b0};
        vecs[12] = '{"div_5_9",      OP_DIV, 32'd5,        32'd9,        34, 32'd5,         32'd0,         1'b0};
        vecs[13] = '{"div_min_2",    OP_DIV, 32'h8000_0000, 32'd2,        34, 32'd0,         32'hC000_0000, 1'b0};
        vecs[14] = '{"div_max_1",    OP_DIV, 32'h7FFF_FFFF, 32'd1,        34, 32'd0,         32'h7FFF_FFFF, 1'b0};
        vecs[15] = '{"mul_x_0",      OP_MUL, 32'h1234_5678, 32'd0,        33, 32'd0,         32'd0,         1'b0};

        clear  = 1'b1;
        start  = 1'b0;
        opcode = OP_ADD;
        A      = '0;
        B      = '0;

        // Reset takes effect before any clock edge and holds across edges.
        #2 clear = 1'b0;
        #1;
        check("reset_async.flags", 64'({busy, done, div_by_zero}), 64'(0));
        check("reset_async.hi", 64'(C_out_HI), 64'(0));
        check("reset_async.lo", 64'(C_out_LO), 64'(0));
        repeat (3) @(posedge clock);
        #1;
        check("reset_hold.flags", 64'({busy, done, div_by_zero}), 64'(0));

        // Release clear and request at once: the first edge must accept it.
        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].op == OP_DIV && !DIV_EN)
                check_ignored({vecs[i].name, "_ignored"}, vecs[i].op, vecs[i].a, vecs[i].b);
            else
                run_op(vecs[i]);
        end

        // Unsupported opcode is ignored.
        check_ignored("add_ignored", OP_ADD, 32'd5, 32'd6);

        // Div request while a Mul is busy must be ignored.
        start  = 1'b1;
        opcode = OP_MUL;
        A      = 32'hFFFF_FFFD;
        B      = 32'd5;
        lat    = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clock);
            #1;
            if (e == 1) start = 1'b0;
            if (e == 4) begin
                start  = 1'b1;
                opcode = OP_DIV;
                A      = 32'd13;
                B      = 32'd0;
            end
            if (e == 5) start = 1'b0;
            if (done) begin
                lat = e;
                break;
            end
        end
        $display("busy_div_start mul -3*5 with Div request at edge 5 -> edges=%0d HI=%h LO=%h dbz=%b",
                 lat, C_out_HI, C_out_LO, div_by_zero);
        check("busy_div_start.latency", 64'(lat), 64'(33));
        check("busy_div_start.hi", 64'(C_out_HI), 64'(32'hFFFF_FFFF));
        check("busy_div_start.lo", 64'(C_out_LO), 64'(32'hFFFF_FFF1));
        check("busy_div_start.dbz", 64'(div_by_zero), 64'(0));
        @(posedge clock);
        #1;
        check("busy_div_start.idle_after", 64'(busy), 64'(0));

        // Reset in the middle of a Mul aborts it without a done pulse.
        start  = 1'b1;
        opcode = OP_MUL;
        A      = 32'd6;
        B      = 32'd7;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clock);
            #1;
            if (e == 1) start = 1'b0;
        end
        clear = 1'b0;
        #1;
        check("abort.flags", 64'({busy, done, div_by_zero}), 64'(0));
        check("abort.hi", 64'(C_out_HI), 64'(0));
        check("abort.lo", 64'(C_out_LO), 64'(0));
        @(posedge clock);
        @(negedge clock);
        clear    = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) done_cnt++;
        end
        $display("abort          mul 6*7 cleared at edge 10 -> done pulses=%0d busy=%b LO=%h",
                 done_cnt, busy, C_out_LO);
        check("abort.no_done", 64'(done_cnt), 64'(0));
        check("abort.idle", 64'(busy), 64'(0));
        check("abort.lo_after", 64'(C_out_LO), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand and per-half result width; only 32 is supported.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 opcode  input  5  operation select: Mul=5'b01111, Div=5'b10000; all other values are ignored.
REQ-006 A  input  32  multiplicand or dividend, signed two's complement.
REQ-007 B  input  32  multiplier or divisor, signed two's complement.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking valid results.
REQ-010 div_by_zero  output  1  status of the last Div; valid from done until the next accepted start.
REQ-011 C_out_HI  output  32  high word to the Z register: Mul product[63:32] or Div remainder.
REQ-012 C_out_LO  output  32  low word to the Z register: Mul product[31:0] or Div quotient.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, MUL, DIV, FIX.
REQ-014 IDLE with start=1 and opcode=Mul SHALL latch A and B, clear the iteration counter, go to MUL and set busy on the same edge.
REQ-015 IDLE with start=1 and opcode=Div SHALL behave the same as REQ-014, but go to DIV.
REQ-016 start with any other opcode, or start while busy=1, SHALL be ignored with no state change.
REQ-017 MUL SHALL perform a radix-2 Booth multiply, one iteration per clock, for 32 iterations.
REQ-018 After the 32nd MUL iteration the FSM SHALL return to IDLE, present the full signed 64-bit product, drop busy and pulse done.
REQ-019 Mul latency SHALL be 33 rising edges from the accepted-start edge to done=1, inclusive of the start edge.
REQ-020 DIV SHALL perform 32 iterations of non-restoring division on the operand magnitudes, one iteration per clock, then enter FIX.
REQ-021 FIX SHALL, in one cycle, apply the remainder correction and signs, pulse done and return to IDLE.
REQ-022 Div quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-023 Div latency SHALL be 34 rising edges.
REQ-024 For Div with B=0, the block SHALL skip the iterations and go to FIX directly.
REQ-025 The B=0 result SHALL be done 2 edges after start, div_by_zero=1, C_out_LO=32'hFFFFFFFF and C_out_HI=A.
REQ-026 Div with A=32'h80000000 and B=32'hFFFFFFFF SHALL give C_out_LO=32'h80000000, C_out_HI=0 and div_by_zero=0.
REQ-027 C_out_HI and C_out_LO SHALL be registered.
REQ-028 C_out_HI and C_out_LO SHALL hold the last result until the next done; they are not guaranteed while busy=1.
REQ-029 done and busy SHALL never be high in the same cycle.
REQ-030 A new start SHALL be accepted in the cycle in which done=1, because the FSM is already in IDLE.
REQ-031 Changes on A, B and opcode after the start edge SHALL NOT affect the operation in progress.

Reset
REQ-032 While clear=0, the state SHALL be IDLE and busy=0, done=0, div_by_zero=0, C_out_HI=0, C_out_LO=0, counter=0, regardless of clock.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-034 The first start SHALL be accepted on the first rising edge after clear deasserts.

Configuration
REQ-035 With macro MULDIV_DIV_EN defined, Div SHALL be supported as specified.
REQ-036 With MULDIV_DIV_EN undefined, the DIV and FIX logic SHALL be omitted and opcode Div SHALL be ignored as in REQ-016.
REQ-037 With MULDIV_DIV_EN undefined, div_by_zero SHALL be tied to 0.

Verification
REQ-038 Mul A=6, B=7 -> done on edge 33, C_out_HI=0, C_out_LO=42.
REQ-039 Mul A=-3, B=5 -> C_out_HI=32'hFFFFFFFF, C_out_LO=32'hFFFFFFF1.
REQ-040 Mul A=B=32'h80000000 -> C_out_HI=32'h40000000, C_out_LO=0.
REQ-041 Div A=-7, B=2 -> done on edge 34, C_out_LO=32'hFFFFFFFD, C_out_HI=32'hFFFFFFFF.
REQ-042 Div A=13, B=0 -> done on edge 2, div_by_zero=1, C_out_LO=32'hFFFFFFFF, C_out_HI=13.
REQ-043 Mul started, clear pulsed low at edge 10 -> outputs 0, no done.
REQ-044 Mul started, then start with opcode Div at edge 5 -> the Div start is ignored and the Mul result is correct.
REQ-045 start with opcode=Add -> busy stays 0.
